mc_seq_ctrl: RTL
================

Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS datapath (IFU, GRF, ALU, DM, EXT, bCheck).
- Splits each instruction into IF/ID/EX/MEM/WB states and issues the write strobes (PC, IR, GRF, DM) on the correct cycle.
- Handles a ready handshake on data memory with a timeout, and keeps cycle and retired-instruction counters.
- The existing combinational Controller still produces the mux selects; this block only sequences them.

Parameters:
- CNT_W, 32, width of the cycle and retired-instruction counters (wrap modulo 2^CNT_W).
- MEM_TO, 16, maximum cycles spent in MEM waiting for mem_ready before abort; valid range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- opcode  in  6  instr[31:26] from the IR.
- funct  in  6  instr[5:0] from the IR.
- mem_ready  in  1  DM handshake; access completes in any cycle where mem_req=1 and mem_ready=1.
- ir_we  out  1  latch fetched instruction into IR.
- pc_we  out  1  load next_pc (supplied by the datapath) into PC.
- reg_we  out  1  GRF write enable.
- mem_req  out  1  DM access request.
- mem_we  out  1  DM write qualifier; only valid while mem_req=1.
- state  out  3  current state encoding, for debug.
- illegal  out  1  sticky flag: an unrecognised opcode/funct was decoded.
- bus_err  out  1  sticky flag: a MEM timeout occurred.
- cyc_cnt  out  CNT_W  cycles since reset.
- ret_cnt  out  CNT_W  instructions retired (cycles with pc_we=1).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IF.
  - cyc_cnt=0, ret_cnt=0, illegal=0, bus_err=0, wait counter=0.
  - All strobes forced to 0 while reset=0.
- Strobes are combinational from state, the decoded class and mem_ready.
- Decoded classes:
  - RALU: opcode 0, funct not jr.
  - IALU: ori, lui, addi.
  - LOAD: lw, lh, lb.
  - STORE: sw, sh, sb.
  - BR: beq, bne.
  - J, JAL.
  - JR: opcode 0, funct 001000.
  - ILL: anything else.
- State transitions:
  - IF: ir_we=1 → ID.
  - ID, class J/JR: pc_we=1 → IF.
  - ID, class JAL: pc_we=1 and reg_we=1 (link value computed from the pre-update PC) → IF.
  - ID, class ILL: pc_we=1, set illegal → IF (executes as a NOP).
  - ID, all other classes: → EX.
  - EX, class BR: pc_we=1 → IF. The datapath chooses target or pc+4 from cmp_check; the controller does not read cmp_check.
  - EX, class RALU/IALU: → WB.
  - EX, class LOAD/STORE: → MEM, wait counter cleared.
  - MEM: mem_req=1; mem_we=1 for STORE only.
  - MEM, mem_ready=1 with STORE: pc_we=1 → IF.
  - MEM, mem_ready=1 with LOAD: → WB.
  - MEM, mem_ready=0: wait counter increments.
  - MEM, wait counter reaches MEM_TO-1 with mem_ready still 0: set bus_err, pc_we=1, reg_we=0 → IF (instruction abandoned, no writeback).
  - WB: reg_we=1, pc_we=1 → IF.
- Latency per instruction:
  - J, JR, JAL, ILL: 2 cycles.
  - BR: 3 cycles.
  - RALU, IALU: 4 cycles.
  - STORE: 4 + wait cycles.
  - LOAD: 5 + wait cycles.
- mem_ready is ignored outside MEM. mem_ready=1 on the first MEM cycle gives zero wait.
- cyc_cnt increments every cycle out of reset. ret_cnt increments on every pc_we=1, including ILL and timeouts. Both wrap to 0 from 2^CNT_W−1.
- illegal and bus_err clear only on reset.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4.
- Unused encodings 5–7 recover to IF on the next edge with all strobes 0.
- Reset asserted in any state (including mid-MEM) aborts immediately. No DM write may be issued after reset is asserted.

Decomposition:
- Shared package mc_pkg:
  - Opcode and funct constants (R=000000, ori=001101, lui=001111, addi=001000, lw=100011, lh=100001, lb=100000, sw=101011, sh=101001, sb=101000, beq=000100, bne=000101, j=000010, jal=000011, jr funct=001000).
  - State encodings.
  - Class enum.
- Sub-module mc_decode: pure combinational opcode/funct → class. The FSM, wait counter and performance counters stay in mc_seq_ctrl.

Test Plan:
- Reset held 3 cycles then released, IR holds addu (0x00000021):
  - Strobe sequence is ir_we, —, —, reg_we+pc_we.
  - ret_cnt=1 after 4 cycles; cyc_cnt=4.
- lw (opcode 100011), mem_ready low 2 cycles then high:
  - Sequence IF, ID, EX, MEM×3, WB.
  - mem_we=0 throughout; reg_we only in WB; ret_cnt +1 after 7 cycles.
- sw (opcode 101011), mem_ready=1 immediately:
  - MEM cycle shows mem_req=1, mem_we=1, pc_we=1 together.
  - No reg_we at any point; 4 cycles total.
- jal (opcode 000011): ID cycle has pc_we=1 and reg_we=1; 2 cycles total. jr (funct 001000): pc_we=1 and reg_we=0.
- MEM_TO=4, lw with mem_ready stuck at 0:
  - Exactly 4 MEM cycles, then bus_err=1, pc_we=1, no reg_we.
  - Next instruction fetches normally.
- Opcode 111111: illegal=1 and pc_we in ID; the flag stays set through subsequent instructions. Reset pulsed during MEM of an sw: mem_req drops asynchronously and state=IF.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencing controller:
// MIPS opcode/funct constants, FSM state encodings and decoded instruction classes.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_RALU,
        C_IALU,
        C_LOAD,
        C_STORE,
        C_BR,
        C_J,
        C_JAL,
        C_JR,
        C_ILL
    } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR opcode/funct fields onto the
// coarse class that decides how many states the sequencer walks through.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls
);

    always_comb begin
        cls = C_ILL;
        case (opcode)
            OP_R:                      cls = (funct == FN_JR) ? C_JR : C_RALU;
            OP_ORI, OP_LUI, OP_ADDI:   cls = C_IALU;
            OP_LW, OP_LH, OP_LB:       cls = C_LOAD;
            OP_SW, OP_SH, OP_SB:       cls = C_STORE;
            OP_BEQ, OP_BNE:            cls = C_BR;
            OP_J:                      cls = C_J;
            OP_JAL:                    cls = C_JAL;
            default:                   cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: walks IF/ID/EX/MEM/WB, issues the
// PC/IR/GRF/DM strobes, times out stalled memory accesses and keeps perf counters.
module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TO - 1);

    cls_t             cls;
    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             timeout;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    // The last permitted MEM cycle with no ready abandons the access.
    assign timeout = (state_q == S_MEM) && !mem_ready && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cyc_q     <= '0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (cls)
                    C_J, C_JR, C_JAL, C_ILL: state_d = S_IF;
                    default:                 state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_RALU, C_IALU:  state_d = S_WB;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    state_d = (cls == C_STORE) ? S_IF : S_WB;
                else if (timeout) state_d = S_IF;
                else              state_d = S_MEM;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Strobes are gated by reset so nothing reaches the datapath while it is held.
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_we  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        if (reset) begin
            case (state_q)
                S_IF: ir_we = 1'b1;
                S_ID: begin
                    case (cls)
                        C_J, C_JR, C_ILL: pc_we = 1'b1;
                        C_JAL: begin
                            pc_we  = 1'b1;
                            reg_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EX: pc_we = (cls == C_BR);
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == C_STORE);
                    pc_we   = (mem_ready && cls == C_STORE) || timeout;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_q == S_EX)
            wait_d = '0;
        else if (state_q == S_MEM && !mem_ready && !timeout)
            wait_d = wait_q + 8'd1;
        illegal_d = illegal_q | ((state_q == S_ID) && (cls == C_ILL));
        bus_err_d = bus_err_q | timeout;
        cyc_d     = cyc_q + CNT_W'(1);
        ret_d     = ret_q + CNT_W'(pc_we);
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;

endmodule
